// File: rtl/digit_window_sampler.sv
// digit_window_sampler: taps a raster-ordered grayscale stream, box-averages a
// fixed window into an 11x11 grid of cells and publishes the grid as a stable
// byte array, pulsing oDone whenever a fresh array has been loaded.
//
// Handshake: the input stream has no back-pressure. A pixel is consumed in any
// cycle where iValid=1, and iX/iY/iPixel are only meaningful in that cycle.
// oDone is a one-cycle strobe; numero is valid and stable from the cycle in
// which oDone is high until the next oDone.
module digit_window_sampler #(
   parameter int X0     = 100,
   parameter int Y0     = 50,
   parameter int CELL_W = 4,
   parameter int CELL_H = 4
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic                    iStart,
   input  logic                    iSof,
   input  logic                    iValid,
   input  logic [9:0]              iX,
   input  logic [9:0]              iY,
   input  logic [7:0]              iPixel,
   output logic                    oBusy,
   output logic                    oDone,
   output logic [10:0][10:0][7:0]  numero,
   output logic [1:0]              fsm_state
);

   localparam int LW = $clog2(CELL_W);
   localparam int LH = $clog2(CELL_H);
   localparam int SH = LW + LH;
   localparam int AW = 8 + SH;

   localparam logic [9:0] X0_V = 10'(X0);
   localparam logic [9:0] Y0_V = 10'(Y0);
   localparam logic [9:0] X1_V = 10'(X0 + 11 * CELL_W - 1);
   localparam logic [9:0] Y1_V = 10'(Y0 + 11 * CELL_H - 1);
   localparam logic [9:0] MX   = 10'(CELL_W - 1);
   localparam logic [9:0] MY   = 10'(CELL_H - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t            state, state_n;
   logic [AW-1:0]     acc [0:10];
   logic [10:0][10:0][7:0] staging;

   logic [9:0]        dx, dy;
   logic [3:0]        col, row;
   logic              in_win, accepted, at_origin, at_last, cell_end;
   logic [AW-1:0]     sum;
   logic [7:0]        avg;
   logic              acc_en, acc_clr, fin;

   // Window test, cell index and in-cell position of the current sample.
   assign dx        = iX - X0_V;
   assign dy        = iY - Y0_V;
   assign in_win    = (iX >= X0_V) && (iX <= X1_V) && (iY >= Y0_V) && (iY <= Y1_V);
   assign accepted  = iValid && in_win;
   assign at_origin = (iX == X0_V) && (iY == Y0_V);
   assign at_last   = (iX == X1_V) && (iY == Y1_V);
   assign col       = 4'(dx >> LW);
   assign row       = 4'(dy >> LH);
   assign cell_end  = ((dx & MX) == MX) && ((dy & MY) == MY);
   assign sum       = acc[col] + AW'(iPixel);
   assign avg       = 8'(sum >> SH);

   assign oBusy     = (state == ARMED) || (state == CAPTURE);
   assign oDone     = (state == DONE);
   assign fsm_state = state;

   // State register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= IDLE;
      else         state <= state_n;
   end

   // Next state plus accumulate / clear / finish strobes. The final window
   // pixel takes priority over a coincident start-of-frame.
   always_comb begin
      state_n = state;
      acc_en  = 1'b0;
      acc_clr = 1'b0;
      fin     = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) state_n = ARMED;
         end
         ARMED: begin
            if (accepted && at_origin) begin
               state_n = CAPTURE;
               acc_en  = 1'b1;
            end
         end
         CAPTURE: begin
            if (accepted && at_last) begin
               state_n = DONE;
               acc_en  = 1'b1;
               fin     = 1'b1;
            end else if (iSof) begin
               state_n = ARMED;
               acc_clr = 1'b1;
            end else if (accepted) begin
               acc_en = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Column accumulators: sum a cell's pixels, restart at the cell's last pixel.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < 11; i++) acc[i] <= '0;
      end else if (acc_clr) begin
         for (int i = 0; i < 11; i++) acc[i] <= '0;
      end else if (acc_en) begin
         if (cell_end) acc[col] <= '0;
         else          acc[col] <= sum;
      end
   end

   // Staging array: truncated cell mean written at each cell's last pixel.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)                  staging <= '0;
      else if (acc_en && cell_end)  staging[row][col] <= avg;
   end

   // Published array: loaded once per completed capture, with the final cell
   // forwarded because its staging write lands on the same edge.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         numero <= '0;
      end else if (fin) begin
         numero         <= staging;
         numero[10][10] <= avg;
      end
   end

endmodule

// File: tb/tb_digit_window_sampler.sv
// Bench for digit_window_sampler: directed frames with hand-computed cell
// means; expected arrays are queued per capture and checked by a monitor
// whenever oDone is seen.
module tb_digit_window_sampler;

   localparam int W = 11 * 11 * 8;

   logic                   iCLK = 1'b0;
   logic                   iRST_N;
   logic                   iStart, iSof, iValid;
   logic [9:0]             iX, iY;
   logic [7:0]             iPixel;
   logic                   oBusy, oDone;
   logic [10:0][10:0][7:0] numero;
   logic [1:0]             fsm_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   digit_window_sampler #(.X0(100), .Y0(50), .CELL_W(4), .CELL_H(4)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iSof(iSof), .iValid(iValid),
      .iX(iX), .iY(iY), .iPixel(iPixel), .oBusy(oBusy), .oDone(oDone),
      .numero(numero), .fsm_state(fsm_state)
   );

   // Clock.
   always #5 iCLK = ~iCLK;

   // Hand-derived expected cell means per frame pattern.
   function automatic logic [7:0] exp_cell(input int mode, input int r, input int c);
      if (mode == 0) return 8'd200;
      if (mode == 2 && r == 2 && c == 3) return 8'd239;
      return 8'(10 * r + c);
   endfunction

   function automatic logic [W-1:0] exp_frame(input int mode);
      logic [W-1:0] v;
      v = '0;
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 11; c++)
            v[(r * 11 + c) * 8 +: 8] = exp_cell(mode, r, c);
      return v;
   endfunction

   // Pixel value for frame pattern; outside the window a bright value is sent.
   function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
      int r, c;
      if (x < 100 || x > 143 || y < 50 || y > 93) return 8'd255;
      r = (y - 50) / 4;
      c = (x - 100) / 4;
      if (mode == 0) return 8'd200;
      if (mode == 2 && r == 2 && c == 3)
         return (((x - 100) % 4 == 1) && ((y - 50) % 4 == 2)) ? 8'd0 : 8'd255;
      return 8'(10 * r + c);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_arr(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < 121; i++) begin
            if (act[i * 8 +: 8] !== exp[i * 8 +: 8]) begin
               $display("FAIL %s: first bad cell [%0d][%0d] actual=%0d required=%0d",
                        name, i / 11, i % 11, act[i * 8 +: 8], exp[i * 8 +: 8]);
               break;
            end
         end
      end
   endtask

   // Scoreboard monitor: every oDone must match the oldest queued array.
   always @(negedge iCLK) begin
      if (iRST_N && oDone) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual=1 required=0 at %0t", $time);
         end else begin
            chk_arr("numero_at_done", numero, exp_q.pop_front());
         end
      end
   end

   // One stimulus cycle.
   task automatic cyc(input bit v, input int x, input int y, input int p,
                      input bit sof, input bit start);
      iValid = v;
      iX     = 10'(x);
      iY     = 10'(y);
      iPixel = 8'(p);
      iSof   = sof;
      iStart = start;
      @(posedge iCLK);
      #1;
   endtask

   // Raster frame over lines 49..94 and columns 98..145. stop_kind 1 aborts
   // with iSof at line stop_y, stop_kind 2 with a 2-cycle reset there.
   task automatic run_frame(input int mode, input int stop_y, input int stop_kind,
                            input bit expect_done);
      cyc(0, 0, 0, 0, 1, 0);
      for (int y = 49; y <= 94; y++) begin
         if (y == stop_y) begin
            if (stop_kind == 1) begin
               cyc(0, 0, 0, 0, 1, 0);
            end else begin
               iValid = 1'b0;
               iRST_N = 1'b0;
               repeat (2) @(posedge iCLK);
               #1;
               iRST_N = 1'b1;
            end
            return;
         end
         if (mode == 3 && y == 60) cyc(0, 98, y, 0, 0, 1);
         for (int x = 98; x <= 145; x++) begin
            if (mode == 3 && x >= 120 && x <= 123 && y >= 70 && y <= 73)
               cyc(0, x, y, 255, 0, 0);
            if (x == 120) cyc(0, x, y, 255, 0, 0);
            cyc(1, x, y, pix_val(mode, x, y), 0, 0);
            if (expect_done && x == 143 && y == 93) chk("done_latency", oDone, 1);
         end
      end
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      iRST_N = 1'b0;
      iStart = 1'b0;
      iSof   = 1'b0;
      iValid = 1'b0;
      iX     = '0;
      iY     = '0;
      iPixel = '0;
      repeat (3) @(posedge iCLK);
      #1;
      chk("reset_busy", oBusy, 0);
      chk("reset_done", oDone, 0);
      chk("reset_state", fsm_state, 0);
      chk_arr("reset_numero", numero, '0);
      iRST_N = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);

      // 1: constant 200 frame.
      cyc(0, 0, 0, 0, 0, 1);
      chk("busy_armed", oBusy, 1);
      exp_q.push_back(exp_frame(0));
      run_frame(0, -1, 0, 1);
      chk("done_one_cycle", oDone, 0);
      chk("idle_after_done", oBusy, 0);

      // 2: per-cell pattern 10*r+c.
      cyc(0, 0, 0, 0, 0, 1);
      exp_q.push_back(exp_frame(1));
      run_frame(1, -1, 0, 1);
      chk("cell_10_10", numero[10][10], 110);
      chk("cell_3_7", numero[3][7], 37);

      // 3: one cell 15x255 + 1x0.
      cyc(0, 0, 0, 0, 0, 1);
      exp_q.push_back(exp_frame(2));
      run_frame(2, -1, 0, 1);
      chk("cell_2_3", numero[2][3], 239);
      chk("cell_2_2", numero[2][2], 22);
      chk("cell_2_4", numero[2][4], 24);
      chk("cell_1_3", numero[1][3], 13);

      // 4: iSof abort at line 70, then a full frame while re-armed.
      cyc(0, 0, 0, 0, 0, 1);
      run_frame(1, 70, 1, 0);
      chk("busy_rearmed", oBusy, 1);
      chk_arr("numero_kept_sof", numero, exp_frame(2));
      exp_q.push_back(exp_frame(0));
      run_frame(0, -1, 0, 1);

      // 5: reset at line 80, an unarmed frame, then an armed one.
      cyc(0, 0, 0, 0, 0, 1);
      run_frame(1, 80, 2, 0);
      chk_arr("numero_cleared", numero, '0);
      chk("busy_after_reset", oBusy, 0);
      run_frame(1, -1, 0, 0);
      chk("busy_unarmed", oBusy, 0);
      cyc(0, 0, 0, 0, 0, 1);
      exp_q.push_back(exp_frame(2));
      run_frame(2, -1, 0, 1);

      // 6: iStart during capture and invalid 255 samples across cell (5,5).
      cyc(0, 0, 0, 0, 0, 1);
      exp_q.push_back(exp_frame(3));
      run_frame(3, -1, 0, 1);
      chk("cell_5_5", numero[5][5], 55);

      repeat (5) cyc(0, 0, 0, 0, 0, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
